// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: turns a single load/store from the EXE/MEM register
// into a WAIT_CYCLES-long synchronous SRAM access and stalls the pipeline meanwhile.
module mem_stage_sram_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              wb_enable_in,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    output logic              wb_enable_out,
    output logic              ready,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0]  CNT_INIT = 8'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE32   = 32'(BASE_ADDR);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        counter;
    logic              req;
    logic              last_beat;
    logic [31:0]       offset;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_offset_bits;

    assign req = mem_read | mem_write;

    // Subtraction wraps modulo 2^32, so after truncation addresses below the
    // base land modulo 2^ADDR_W without any special case.
    assign offset             = address - BASE32;
    assign word_addr          = offset[ADDR_W+1:2];
    assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};

    assign last_beat = (state == ACCESS) && (counter == 8'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = ACCESS;
            ACCESS:  if (counter == 8'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DONE releases the pipeline even if the request lines are still high:
    // that request belongs to the instruction leaving on this edge.
    always_comb begin
        ready         = ((state == IDLE) && !req) || (state == DONE);
        wb_enable_out = wb_enable_in & ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter    <= 8'd0;
            read_data  <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        sram_en    <= 1'b1;
                        sram_we    <= mem_write;
                        sram_addr  <= word_addr;
                        sram_wdata <= write_data;
                        counter    <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (last_beat) begin
                        if (!sram_we) read_data <= sram_rdata;
                        sram_en <= 1'b0;
                        sram_we <= 1'b0;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a small behavioural word SRAM.
module tb_mem_stage_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic        wb_enable_in;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        wb_enable_out;
    logic        ready;
    logic        sram_en;
    logic        sram_we;
    logic [15:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int checks = 0;
    int errors = 0;

    mem_stage_sram_ctrl #(
        .DATA_W(32), .ADDR_W(16), .BASE_ADDR(1024), .WAIT_CYCLES(5)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .wb_enable_in(wb_enable_in), .address(address), .write_data(write_data),
        .read_data(read_data), .wb_enable_out(wb_enable_out), .ready(ready),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 16 words, word 2 preloaded on reset.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) mem[k] <= 32'h0;
            mem[2] <= 32'h12345678;
        end else if (sram_en && sram_we) begin
            mem[sram_addr[3:0]] <= sram_wdata;
        end
    end
    assign sram_rdata = (sram_en && !sram_we) ? mem[sram_addr[3:0]] : 32'h0;

    // Drives one request from IDLE until the DONE cycle is observed, then
    // steps past DONE and drops the request. Returns what it saw.
    task automatic run_req(input logic rd, input logic wr, input logic wbe,
                           input logic [31:0] addr, input logic [31:0] wdat,
                           output int low, output int en_n, output int we_n,
                           output logic [15:0] first_addr, output logic [31:0] first_wdata,
                           output logic held, output int wb_frz,
                           output logic done_wb, output logic done_en,
                           output logic [31:0] done_rd);
        low = 0; en_n = 0; we_n = 0; wb_frz = 0; held = 1'b1;
        first_addr = '0; first_wdata = '0; done_wb = 1'b0; done_en = 1'b1; done_rd = '0;
        mem_read = rd; mem_write = wr; wb_enable_in = wbe;
        address = addr; write_data = wdat;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sram_en) begin
                if (en_n == 0) begin
                    first_addr = sram_addr; first_wdata = sram_wdata;
                end else if (sram_addr != first_addr || sram_wdata != first_wdata) begin
                    held = 1'b0;
                end
                en_n++;
                if (sram_we) we_n++;
            end
            if (ready) begin
                done_wb = wb_enable_out; done_en = sram_en; done_rd = read_data;
                break;
            end
            low++;
            if (wb_enable_out) wb_frz++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; wb_enable_in = 1'b1;
        address = 32'h0; write_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (read_data !== 32'h0 || sram_en !== 1'b0 || sram_we !== 1'b0 ||
            sram_addr !== 16'h0 || sram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_regs: rd=%h en=%b we=%b addr=%h wd=%h, required all zero",
                     read_data, sram_en, sram_we, sram_addr, sram_wdata);
        end
        checks++;
        if (ready !== 1'b1 || wb_enable_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b wb_out=%b, required 1 1", ready, wb_enable_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_idle;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ready !== 1'b1 || wb_enable_out !== 1'b1 || sram_en !== 1'b0) begin
                errors++;
                $display("FAIL idle_pass cycle %0d: ready=%b wb_out=%b en=%b, required 1 1 0",
                         c, ready, wb_enable_out, sram_en);
            end
            @(posedge clk); #1;
        end
        wb_enable_in = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_enable_out !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_wb0: wb_out=%b ready=%b, required 0 1", wb_enable_out, ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        int low, en_n, we_n, wb_frz; logic [15:0] fa; logic [31:0] fw, drd;
        logic held, dwb, den;
        run_req(1'b1, 1'b0, 1'b1, 32'd1032, 32'h0, low, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        checks++;
        if (low != 6 || en_n != 5 || we_n != 0) begin
            errors++;
            $display("FAIL load_timing: low=%0d en=%0d we=%0d, required 6 5 0", low, en_n, we_n);
        end
        checks++;
        if (fa !== 16'd2 || !held) begin
            errors++;
            $display("FAIL load_addr: addr=%0d held=%b, required 2 1", fa, held);
        end
        checks++;
        if (drd !== 32'h12345678) begin
            errors++;
            $display("FAIL load_data: got %h, required 12345678", drd);
        end
        checks++;
        if (wb_frz != 0 || dwb !== 1'b1 || den !== 1'b0) begin
            errors++;
            $display("FAIL load_wb: wb_in_freeze=%0d wb_done=%b en_done=%b, required 0 1 0",
                     wb_frz, dwb, den);
        end
        @(negedge clk);
        checks++;
        if (read_data !== 32'h12345678 || ready !== 1'b1) begin
            errors++;
            $display("FAIL load_hold: rd=%h ready=%b, required 12345678 1", read_data, ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store;
        int low, en_n, we_n, wb_frz; logic [15:0] fa; logic [31:0] fw, drd;
        logic held, dwb, den;
        run_req(1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, low, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        checks++;
        if (low != 6 || en_n != 5 || we_n != 5 || den !== 1'b0) begin
            errors++;
            $display("FAIL store_timing: low=%0d en=%0d we=%0d en_done=%b, required 6 5 5 0",
                     low, en_n, we_n, den);
        end
        checks++;
        if (fa !== 16'd2 || fw !== 32'hDEADBEEF || !held) begin
            errors++;
            $display("FAIL store_bus: addr=%0d wd=%h held=%b, required 2 deadbeef 1", fa, fw, held);
        end
        checks++;
        if (drd !== 32'h12345678 || mem[2] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_effect: rd=%h mem2=%h, required 12345678 deadbeef", drd, mem[2]);
        end
    endtask

    task automatic test_back_to_back;
        int low1, low2, en_n, we_n, wb_frz; logic [15:0] fa; logic [31:0] fw, drd;
        logic held, dwb, den;
        run_req(1'b0, 1'b1, 1'b0, 32'd1024, 32'hA5A5A5A5, low1, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        run_req(1'b1, 1'b0, 1'b1, 32'd1024, 32'h0, low2, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        checks++;
        if (low1 + low2 != 12) begin
            errors++;
            $display("FAIL b2b_low: total ready-low=%0d, required 12", low1 + low2);
        end
        checks++;
        if (drd !== 32'hA5A5A5A5 || fa !== 16'd0 || we_n != 0) begin
            errors++;
            $display("FAIL b2b_load: rd=%h addr=%0d we=%0d, required a5a5a5a5 0 0", drd, fa, we_n);
        end
    endtask

    task automatic test_both;
        int low, en_n, we_n, wb_frz; logic [15:0] fa; logic [31:0] fw, drd;
        logic held, dwb, den;
        run_req(1'b1, 1'b1, 1'b1, 32'd1028, 32'h0BADF00D, low, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        checks++;
        if (we_n != 5 || fa !== 16'd1 || low != 6) begin
            errors++;
            $display("FAIL both_write: we=%0d addr=%0d low=%0d, required 5 1 6", we_n, fa, low);
        end
        checks++;
        if (drd !== 32'hA5A5A5A5 || mem[1] !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL both_data: rd=%h mem1=%h, required a5a5a5a5 0badf00d", drd, mem[1]);
        end
        run_req(1'b1, 1'b0, 1'b0, 32'd1029, 32'h0, low, en_n, we_n, fa, fw, held,
                wb_frz, dwb, den, drd);
        checks++;
        if (drd !== 32'h0BADF00D || fa !== 16'd1 || dwb !== 1'b0) begin
            errors++;
            $display("FAIL offset_load: rd=%h addr=%0d wb=%b, required 0badf00d 1 0", drd, fa, dwb);
        end
    endtask

    task automatic test_reset_mid;
        mem_read = 1'b1; address = 32'd1032; wb_enable_in = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || sram_en !== 1'b1) begin
            errors++;
            $display("FAIL mid_before: ready=%b en=%b, required 0 1", ready, sram_en);
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if (sram_en !== 1'b0 || sram_we !== 1'b0 || read_data !== 32'h0 || sram_addr !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset: en=%b we=%b rd=%h addr=%h, required 0 0 0 0",
                     sram_en, sram_we, read_data, sram_addr);
        end
        checks++;
        if (ready !== 1'b1 || wb_enable_out !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready: ready=%b wb_out=%b, required 1 1", ready, wb_enable_out);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load();
        test_store();
        test_back_to_back();
        test_both();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
